// File: rtl/mult_div_unit_pkg.sv
// Shared constants and helpers for the sequential multiply/divide unit:
// function codes, FSM state encoding and the iteration count.
package mult_div_unit_pkg;

    // R-type function codes handled by the unit
    localparam logic [5:0] FUNC_MFHI  = 6'd16;
    localparam logic [5:0] FUNC_MTHI  = 6'd17;
    localparam logic [5:0] FUNC_MFLO  = 6'd18;
    localparam logic [5:0] FUNC_MTLO  = 6'd19;
    localparam logic [5:0] FUNC_MULT  = 6'd24;
    localparam logic [5:0] FUNC_MULTU = 6'd25;
    localparam logic [5:0] FUNC_DIV   = 6'd26;
    localparam logic [5:0] FUNC_DIVU  = 6'd27;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_SIGN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // One iteration per operand bit
    localparam int                ITER_COUNT = 32;
    localparam int                ITER_W     = $clog2(ITER_COUNT);
    localparam logic [ITER_W-1:0] LAST_ITER  = ITER_W'(ITER_COUNT - 1);

    // Multiply or divide: the ops that run the iterative datapath
    function automatic logic is_md_op(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_MULTU) || (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

    // HI/LO move ops: complete in a single edge
    function automatic logic is_mv_op(input logic [5:0] f);
        return (f == FUNC_MFHI) || (f == FUNC_MTHI) || (f == FUNC_MFLO) || (f == FUNC_MTLO);
    endfunction

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FUNC_DIV) || (f == FUNC_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FUNC_MULT) || (f == FUNC_DIV);
    endfunction

    // Absolute value when the operand is treated as two's complement;
    // 0x80000000 maps to 2^31, which is still correct as an unsigned magnitude
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// Combinational single iteration of the multiply/divide datapath.
// Multiply: {acc_hi, acc_lo} holds {partial product, remaining multiplier};
//           add the multiplicand when the multiplier LSB is set, shift right.
// Divide:   {acc_hi, acc_lo} holds {partial remainder, remaining dividend};
//           shift left, trial-subtract the divisor, keep it if no borrow.
module md_iter_step (
    input  logic        is_div,
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
    input  logic [31:0] operand,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic [32:0] sum;
    logic [32:0] r_shift;
    logic [31:0] diff;
    logic        fits;

    // Compute both step flavours and select by operation type
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via the if/else covering both) so no latch is inferred.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);
        r_shift = {acc_hi, acc_lo[31]};
        fits    = (r_shift >= {1'b0, operand});
        // When the trial succeeds the difference is below the divisor, so
        // the 32-bit wrap-around subtraction is exact.
        diff    = r_shift[31:0] - operand;
        if (is_div) begin
            next_hi = fits ? diff : r_shift[31:0];
            next_lo = {acc_lo[30:0], fits};
        end else begin
            next_hi = sum[32:1];
            next_lo = {sum[0], acc_lo[31:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential MIPS-style multiply/divide unit with HI/LO registers.
// Iterates 32 times on operand magnitudes, then applies sign correction
// in a single SIGN cycle before signalling completion.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  func,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic [1:0]        state;
    logic [ITER_W-1:0] iter_cnt;
    logic [5:0]        func_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       operand_q;
    logic [31:0]       acc_hi;
    logic [31:0]       acc_lo;
    logic [31:0]       step_hi;
    logic [31:0]       step_lo;
    logic [31:0]       fix_hi;
    logic [31:0]       fix_lo;
    logic [63:0]       prod_neg;
    logic              a_neg;
    logic              b_neg;
    logic              op_div;
    logic              b_zero;

    assign op_div = is_div_op(func_q);
    assign b_zero = (b_q == 32'd0);
    assign a_neg  = is_signed_op(func_q) & a_q[31];
    assign b_neg  = is_signed_op(func_q) & b_q[31];
    assign busy   = (state == ST_CALC) || (state == ST_SIGN);
    assign done   = (state == ST_DONE);

    md_iter_step u_step (
        .is_div  (op_div),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    // Sign correction and divide-by-zero override of the raw magnitudes
    always_comb begin
        fix_hi   = acc_hi;
        fix_lo   = acc_lo;
        prod_neg = 64'd0 - {acc_hi, acc_lo};
        if (op_div) begin
            if (b_zero) begin
                fix_hi = a_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                // Quotient truncates toward zero; remainder follows dividend
                if (a_neg ^ b_neg) fix_lo = 32'd0 - acc_lo;
                if (a_neg)         fix_hi = 32'd0 - acc_hi;
            end
        end else if (a_neg ^ b_neg) begin
            fix_hi = prod_neg[63:32];
            fix_lo = prod_neg[31:0];
        end
    end

    // Control FSM, iteration counter, operand latches and architectural state
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!reset) begin
            state     <= ST_IDLE;
            iter_cnt  <= '0;
            func_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            operand_q <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && is_md_op(func)) begin
                        a_q      <= data_a;
                        b_q      <= data_b;
                        func_q   <= func;
                        iter_cnt <= '0;
                        acc_hi   <= '0;
                        if (is_div_op(func)) begin
                            acc_lo    <= magnitude(data_a, is_signed_op(func));
                            operand_q <= magnitude(data_b, is_signed_op(func));
                        end else begin
                            acc_lo    <= magnitude(data_b, is_signed_op(func));
                            operand_q <= magnitude(data_a, is_signed_op(func));
                        end
                        state <= ST_CALC;
                    end else if (start && is_mv_op(func)) begin
                        div_zero <= 1'b0;
                        state    <= ST_DONE;
                        case (func)
                            FUNC_MTHI: begin hi <= data_a; result <= '0; end
                            FUNC_MTLO: begin lo <= data_a; result <= '0; end
                            FUNC_MFHI: result <= hi;
                            default:   result <= lo;
                        endcase
                    end
                end
                ST_CALC: begin
                    acc_hi   <= step_hi;
                    acc_lo   <= step_lo;
                    iter_cnt <= iter_cnt + 1'b1;
                    if (iter_cnt == LAST_ITER) state <= ST_SIGN;
                end
                ST_SIGN: begin
                    hi       <= fix_hi;
                    lo       <= fix_lo;
                    result   <= '0;
                    div_zero <= op_div & b_zero;
                    state    <= ST_DONE;
                end
                default: begin
                    div_zero <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus random self-checking bench for mult_div_unit. Expected
// completions are pushed to a scoreboard at issue and popped at done.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [5:0]  func;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] result;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_res;
    int          checks;
    int          errors;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .func     (func),
        .data_a   (data_a),
        .data_b   (data_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour built on plain SV arithmetic; updates shadow HI/LO
    task automatic model(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, output exp_t e);
        longint      sa;
        longint      sb_v;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = $signed(a);
        sb_v = $signed(b);
        e.dz = 1'b0;
        e.lat = 33;
        m_res = 32'd0;
        case (f)
            FUNC_MULT: begin p = sa * sb_v; m_hi = p[63:32]; m_lo = p[31:0]; end
            FUNC_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            FUNC_DIV, FUNC_DIVU: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFF_FFFF; e.dz = 1'b1;
                end else if (f == FUNC_DIV) begin
                    q = sa / sb_v; r = sa % sb_v; m_lo = q[31:0]; m_hi = r[31:0];
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            FUNC_MTHI: begin m_hi = a; e.lat = 0; end
            FUNC_MTLO: begin m_lo = a; e.lat = 0; end
            FUNC_MFHI: begin m_res = m_hi; e.lat = 0; end
            default:   begin m_res = m_lo; e.lat = 0; end
        endcase
        e.tag = tag;
        e.hi = m_hi;
        e.lo = m_lo;
        e.result = m_res;
    endtask

    // Present a request for one edge, then scramble the inputs
    task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        func = f; data_a = a; data_b = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        data_a = $urandom;
        data_b = $urandom;
    endtask

    task automatic issue(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        model(tag, f, a, b, e);
        sb.push_back(e);
        drive_start(f, a, b);
        check({tag, "_busy"}, {63'd0, busy}, {63'd0, (e.lat != 0)});
    endtask

    // Wait (bounded) for done, compare against the scoreboard head
    task automatic finish_op(input int skipped);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("sb_nonempty", {63'd0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_latency"}, 64'(n), 64'(e.lat - skipped));
            check({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
            check({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
            check({e.tag, "_result"}, {32'd0, result}, {32'd0, e.result});
            check({e.tag, "_div_zero"}, {63'd0, div_zero}, {63'd0, e.dz});
        end
        @(posedge clock); #1;
        check("done_pulse", {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [5:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0; errors = 0;
        m_hi = 0; m_lo = 0; m_res = 0;
        reset = 1'b0; start = 1'b0; func = '0; data_a = '0; data_b = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_flags", {29'd0, result, busy, done, div_zero}, 64'd0);
        #3 reset = 1'b1;

        // First start right after release; spec vectors
        issue("multu_ff_x2", FUNC_MULTU, 32'hFFFF_FFFF, 32'd2);
        finish_op(0);
        check("multu_ff_x2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        issue("mult_m3_x5", FUNC_MULT, -32'sd3, 32'd5);
        finish_op(0);
        check("mult_m3_x5_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        issue("div_m7_2", FUNC_DIV, -32'sd7, 32'd2);
        finish_op(0);
        check("div_m7_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue("divu_20_20", FUNC_DIVU, 32'd20, 32'd20);
        finish_op(0);
        check("divu_20_20_const", {hi, lo}, 64'h0000_0000_0000_0001);
        issue("div_9_0", FUNC_DIV, 32'd9, 32'd0);
        finish_op(0);
        issue("div_min_m1", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(0);
        check("div_min_m1_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // HI/LO moves complete on the accepting edge
        issue("mthi", FUNC_MTHI, 32'h1234_5678, 32'd0);
        finish_op(0);
        issue("mfhi", FUNC_MFHI, 32'd0, 32'd0);
        finish_op(0);
        check("mfhi_const", {32'd0, result}, 64'h1234_5678);
        issue("mtlo", FUNC_MTLO, 32'hCAFE_F00D, 32'd0);
        finish_op(0);
        issue("mflo", FUNC_MFLO, 32'd0, 32'd0);
        finish_op(0);

        // Unsupported func is ignored: no state change, result held
        drive_start(6'd0, 32'hDEAD_BEEF, 32'd1);
        @(posedge clock); #1;
        check("bad_func_idle", {62'd0, busy, done}, 64'd0);
        check("bad_func_hold", {hi, lo}, {m_hi, m_lo});
        check("bad_func_result", {32'd0, result}, {32'd0, m_res});

        // Second start while busy is ignored; operands are latched
        issue("multu_3_4_busy", FUNC_MULTU, 32'd3, 32'd4);
        repeat (5) begin @(posedge clock); #1; end
        drive_start(FUNC_MTHI, 32'hFFFF_0000, 32'd7);
        finish_op(6);

        // Random multiply/divide against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            rf = FUNC_MULT + 6'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (is_div_op(rf) && rb == 32'd0) rb = 32'd1;
            issue($sformatf("rand%0d", i), rf, ra, rb);
            finish_op(0);
        end

        // Asynchronous reset in the middle of a multiply
        drive_start(FUNC_MULT, 32'd1000, 32'd77);
        repeat (9) begin @(posedge clock); #1; end
        #2 reset = 1'b0;
        #1;
        m_hi = 0; m_lo = 0; m_res = 0;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_result", {32'd0, result}, 64'd0);
        #2 reset = 1'b1;
        issue("multu_1_1", FUNC_MULTU, 32'd1, 32'd1);
        finish_op(0);
        check("multu_1_1_const", {32'd0, lo}, 64'd1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL: clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL: start  input  1  request strobe, sampled only in IDLE.
REQ-004 SHALL: func  input  6  R-type function code: 24 MULT, 25 MULTU, 26 DIV, 27 DIVU, 16 MFHI, 17 MTHI, 18 MFLO, 19 MTLO.
REQ-005 SHALL: data_a  input  32  rs operand (multiplicand/dividend, or MTHI/MTLO source).
REQ-006 SHALL: data_b  input  32  rt operand (multiplier/divisor).
REQ-007 SHALL: busy  output  1  high in CALC and SIGN states.
REQ-008 SHALL: done  output  1  one-cycle completion pulse, high only in DONE.
REQ-009 SHALL: result  output  32  registered HI (MFHI) or LO (MFLO), 0 for all other ops.
REQ-010 SHALL: hi, lo  output  32 each  architectural HI/LO registers.
REQ-011 SHALL: div_zero  output  1  high with done when a DIV/DIVU had data_b = 0.

Function
REQ-012 SHALL: FSM states IDLE, CALC, SIGN, DONE; DONE always returns to IDLE on the next edge.
REQ-013 SHALL: IDLE + start + MULT/MULTU/DIV/DIVU latches data_a, data_b and func, loads iteration count 0, and enters CALC.
REQ-014 SHALL: IDLE + start + MFHI/MFLO/MTHI/MTLO goes to DONE in one edge; MTHI/MTLO write hi/lo on that edge; MFHI/MFLO load result on that edge.
REQ-015 SHALL: IDLE + start with any other func is ignored; the unit stays in IDLE and no outputs change.
REQ-016 SHALL: start outside IDLE is ignored with no queuing; operands held in the latches are immune to input changes.
REQ-017 SHALL: CALC performs exactly 32 iterations on operand magnitudes: shift-add for multiply, restoring shift-subtract for divide.
REQ-018 SHALL: CALC moves to SIGN on the edge completing iteration 31; SIGN applies sign correction and writes hi/lo, then moves to DONE.
REQ-019 SHALL: latency for start sampled at edge k is CALC on edges k+1..k+32, hi/lo valid after edge k+33, done high from k+33 to k+34, IDLE at k+34.
REQ-020 SHALL: MULT/MULTU place the 64-bit product in {hi, lo}; signed ops use two's-complement operands.
REQ-021 SHALL: DIV/DIVU place the quotient in lo and the remainder in hi; signed quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-022 SHALL: signed 0x80000000 / -1 yields lo = 0x80000000, hi = 0, with no flag.
REQ-023 SHALL: divide by zero still takes full latency and yields lo = 0xFFFFFFFF, hi = data_a, div_zero = 1 for the done cycle.
REQ-024 SHALL: hi/lo change only in SIGN, or on MTHI/MTLO acceptance.
REQ-025 SHALL: result holds its value until the next accepted op, which reloads it (0 for non-MF ops) when the op reaches DONE.

Reset
REQ-026 SHALL: reset = 0 at any time, including mid-CALC, forces IDLE immediately with hi = lo = result = 0, busy = done = div_zero = 0, and iteration count 0.
REQ-027 SHALL: the first start is accepted on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL: a shared package holds the func code constants, the FSM state encoding, and ITER_COUNT = 32.
REQ-029 SHALL: a single sub-module md_iter_step implements the combinational one-iteration step (add-or-skip for multiply, trial-subtract for divide); the FSM, counter and registers stay in mult_div_unit.

Verification
REQ-030 SHALL: MULTU a = 0xFFFFFFFF, b = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE, done 33 edges after start.
REQ-031 SHALL: MULT a = -3, b = 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1.
REQ-032 SHALL: DIV a = -7, b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU a = 20, b = 20 -> lo = 1, hi = 0.
REQ-033 SHALL: DIV a = 9, b = 0 -> lo = 0xFFFFFFFF, hi = 9, div_zero = 1 with done.
REQ-034 SHALL: MTHI 0x12345678 then MFHI -> result = 0x12345678, each op with done one edge after start; a second start while busy is ignored.
REQ-035 SHALL: reset = 0 at edge k+10 of a MULT -> busy = 0 and hi = lo = 0 immediately; a new MULTU 1 x 1 after release gives lo = 1.
